// File: rtl/fwd_scoreboard_pkg.sv
// Shared definitions for the operand-forwarding scoreboard: default widths,
// the "no register" index and the forwarding source selector.
package fwd_scoreboard_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int RW_DEFAULT = 5;
  localparam int CNT_W      = 32;

  // Register index 0 means "no destination / no source" and never forwards.
  localparam int RNONE = 0;

  typedef enum logic [1:0] {
    FWD_RF,
    FWD_E,
    FWD_M,
    FWD_STORED
  } fwdSelT;

endpackage

// File: rtl/fwd_port_mux.sv
// One decode read port: youngest-first search of the stage shadow, value select
// and load-use stall request. Purely combinational.
module fwd_port_mux
  import fwd_scoreboard_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1,
  parameter int DW         = DW_DEFAULT,
  parameter int RW         = RW_DEFAULT
) (
  input  logic [RW-1:0]       src,
  input  logic [DW-1:0]       rfVal,
  input  logic [DEPTH-1:0]    entVld,
  input  logic [DEPTH-1:0]    entIsLoad,
  input  logic [DEPTH-1:0]    entOk,
  input  logic [DEPTH*RW-1:0] entDst,
  input  logic [DEPTH*DW-1:0] entVal,
  input  logic [DW-1:0]       eVal,
  input  logic [DW-1:0]       mVal,
  output logic [DW-1:0]       fwdVal,
  output logic                stallReq
);

  fwdSelT          sel;
  logic            hit;
  logic [DW-1:0]   storedVal;

  // Entry 0 is the youngest, so the first valid match in ascending order wins.
  always_comb begin
    sel       = FWD_RF;
    hit       = 1'b0;
    stallReq  = 1'b0;
    storedVal = '0;
    if (src != RW'(RNONE)) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (!hit && entVld[k] && (entDst[k*RW +: RW] == src)) begin
          hit = 1'b1;
          if (k == 0 && !entIsLoad[k]) begin
            sel = FWD_E;
          end else if (entIsLoad[k] && k == LOAD_STAGE) begin
            sel = FWD_M;
          end else if (entOk[k]) begin
            sel       = FWD_STORED;
            storedVal = entVal[k*DW +: DW];
          end else if (entIsLoad[k] && k < LOAD_STAGE) begin
            stallReq = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    case (sel)
      FWD_E:      fwdVal = eVal;
      FWD_M:      fwdVal = mVal;
      FWD_STORED: fwdVal = storedVal;
      default:    fwdVal = rfVal;
    endcase
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Decode-stage forwarding unit: stage shadow shift register, per-port muxes and
// load-use stall. Optional stall-cycle counter enabled by FWD_STALL_CNT_EN.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1,
  parameter int DW         = DW_DEFAULT,
  parameter int RW         = RW_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  d_issue,
  input  logic [RW-1:0]         d_dst,
  input  logic                  d_is_load,
  input  logic [NUM_SRC*RW-1:0] d_srcs,
  input  logic [NUM_SRC*DW-1:0] d_rvals,
  input  logic [DW-1:0]         e_valE,
  input  logic [DW-1:0]         m_valM,
  input  logic                  flush,
  output logic [NUM_SRC*DW-1:0] d_vals,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_cnt
);

  logic [DEPTH-1:0]    entVld;
  logic [DEPTH-1:0]    entIsLoad;
  logic [DEPTH-1:0]    entOk;
  logic [DEPTH*RW-1:0] entDst;
  logic [DEPTH*DW-1:0] entVal;
  logic [NUM_SRC-1:0]  portStall;

  // Shadow advances every cycle; results are captured as an entry leaves the
  // stage that produces them (ALU out of E, load data out of LOAD_STAGE).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entVld    <= '0;
      entIsLoad <= '0;
      entOk     <= '0;
      entDst    <= '0;
      entVal    <= '0;
    end else begin
      entVld[0]        <= d_issue & ~stall & ~flush;
      entDst[0 +: RW]  <= d_dst;
      entIsLoad[0]     <= d_is_load;
      entVal[0 +: DW]  <= '0;
      entOk[0]         <= 1'b0;
      for (int k = 1; k < DEPTH; k++) begin
        entVld[k]            <= (k == 1) ? (entVld[0] & ~flush) : entVld[k-1];
        entDst[k*RW +: RW]   <= entDst[(k-1)*RW +: RW];
        entIsLoad[k]         <= entIsLoad[k-1];
        if (k == 1 && !entIsLoad[0]) begin
          entVal[k*DW +: DW] <= e_valE;
          entOk[k]           <= 1'b1;
        end else if (k == LOAD_STAGE + 1 && entIsLoad[k-1]) begin
          entVal[k*DW +: DW] <= m_valM;
          entOk[k]           <= 1'b1;
        end else begin
          entVal[k*DW +: DW] <= entVal[(k-1)*DW +: DW];
          entOk[k]           <= entOk[k-1];
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : gPort
    fwd_port_mux #(
      .DEPTH      (DEPTH),
      .LOAD_STAGE (LOAD_STAGE),
      .DW         (DW),
      .RW         (RW)
    ) uMux (
      .src       (d_srcs[i*RW +: RW]),
      .rfVal     (d_rvals[i*DW +: DW]),
      .entVld    (entVld),
      .entIsLoad (entIsLoad),
      .entOk     (entOk),
      .entDst    (entDst),
      .entVal    (entVal),
      .eVal      (e_valE),
      .mVal      (m_valM),
      .fwdVal    (d_vals[i*DW +: DW]),
      .stallReq  (portStall[i])
    );
  end

  assign stall = |portStall;

`ifdef FWD_STALL_CNT_EN
  logic [CNT_W-1:0] stallCnt;

  // Saturating count of stalled cycles; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCnt <= '0;
    end else if (stall && (stallCnt != {CNT_W{1'b1}})) begin
      stallCnt <= stallCnt + 1'b1;
    end
  end

  assign stall_cnt = stallCnt;
`else
  assign stall_cnt = '0;
`endif

endmodule
